// File: rtl/issue_sb_queue.sv
// issue_sb_queue: circular scoreboard with in-order issue, out-of-order writeback and in-order commit.
// Entries are indexed by ID; head = commit, iptr = issue, tail = alloc.
module issue_sb_queue #(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_WB_PORTS     = 4,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned PAYLOAD_W       = 64,
  parameter int unsigned XLEN            = 64,
  parameter int unsigned IDW             = $clog2(NR_ENTRIES)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 flush_unissued_i,
  input  logic                                 alloc_valid_i,
  input  logic [PAYLOAD_W-1:0]                 alloc_payload_i,
  output logic                                 alloc_ready_o,
  output logic [IDW-1:0]                       alloc_id_o,
  output logic                                 issue_valid_o,
  output logic [PAYLOAD_W-1:0]                 issue_payload_o,
  output logic [IDW-1:0]                       issue_id_o,
  input  logic                                 issue_ready_i,
  input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
  input  logic [NR_WB_PORTS*IDW-1:0]           wb_id_i,
  input  logic [NR_WB_PORTS*XLEN-1:0]          wb_data_i,
  input  logic [NR_WB_PORTS-1:0]               wb_ex_i,
  output logic [NR_COMMIT_PORTS-1:0]           commit_valid_o,
  output logic [NR_COMMIT_PORTS*PAYLOAD_W-1:0] commit_payload_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]      commit_data_o,
  output logic [NR_COMMIT_PORTS-1:0]           commit_ex_o,
  input  logic [NR_COMMIT_PORTS-1:0]           commit_ack_i,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [IDW:0]                         count_o
);

  localparam int unsigned CNTW = IDW + 1;

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ALLOC  = 2'd1;
  localparam logic [1:0] ST_ISSUED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]           state_q   [NR_ENTRIES];
  logic [1:0]           state_d   [NR_ENTRIES];
  logic [PAYLOAD_W-1:0] payload_q [NR_ENTRIES];
  logic [XLEN-1:0]      data_q    [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] ex_q;

  logic [IDW-1:0]  head_q, head_d;
  logic [IDW-1:0]  iptr_q, iptr_d;
  logic [IDW-1:0]  tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;

  logic                  alloc_fire;
  logic                  issue_fire;
  logic [NR_ENTRIES-1:0] wb_hit;
  logic [XLEN-1:0]       wb_data   [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] wb_ex;
  logic [NR_ENTRIES-1:0] retire_mask;
  logic [CNTW-1:0]       retire_n;
  logic [CNTW-1:0]       unissued_n;

  // Allocation readiness looks only at the registered count, never at this cycle's retirements.
  assign full_o        = (count_q == CNTW'(NR_ENTRIES));
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign alloc_ready_o = !full_o && !flush_i && !flush_unissued_i;
  assign alloc_id_o    = tail_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  assign issue_valid_o   = (state_q[iptr_q] == ST_ALLOC);
  assign issue_payload_o = payload_q[iptr_q];
  assign issue_id_o      = iptr_q;
  assign issue_fire      = issue_valid_o && issue_ready_i && !flush_i && !flush_unissued_i;

  // Ports are scanned highest-first so the lowest-numbered port's write lands last and wins.
  always_comb begin
    for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
      wb_hit[e]  = 1'b0;
      wb_data[e] = '0;
      wb_ex[e]   = 1'b0;
      for (int unsigned i = 0; i < NR_WB_PORTS; i++) begin
        if (wb_valid_i[NR_WB_PORTS-1-i] &&
            (wb_id_i[(NR_WB_PORTS-1-i)*IDW +: IDW] == IDW'(e))) begin
          wb_hit[e]  = 1'b1;
          wb_data[e] = wb_data_i[(NR_WB_PORTS-1-i)*XLEN +: XLEN];
          wb_ex[e]   = wb_ex_i[NR_WB_PORTS-1-i];
        end
      end
      if (state_q[e] != ST_ISSUED) begin
        wb_hit[e] = 1'b0;
      end
    end
  end

  always_comb begin
    logic           run;
    logic           ack_run;
    logic [IDW-1:0] idx;
    run              = 1'b1;
    ack_run          = 1'b1;
    retire_n         = '0;
    retire_mask      = '0;
    commit_valid_o   = '0;
    commit_payload_o = '0;
    commit_data_o    = '0;
    commit_ex_o      = '0;
    for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
      idx                                        = head_q + IDW'(k);
      run                                        = run && (state_q[idx] == ST_DONE);
      commit_valid_o[k]                          = run;
      commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[idx];
      commit_data_o[k*XLEN +: XLEN]              = data_q[idx];
      commit_ex_o[k]                             = ex_q[idx];
      ack_run                                    = ack_run && run && commit_ack_i[k];
      if (ack_run) begin
        retire_n         = retire_n + CNTW'(1);
        retire_mask[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    unissued_n = '0;
    for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
      state_d[e] = state_q[e];
      case (state_q[e])
        ST_FREE: begin
          if (alloc_fire && (tail_q == IDW'(e))) state_d[e] = ST_ALLOC;
        end
        ST_ALLOC: begin
          unissued_n = unissued_n + CNTW'(1);
          if (flush_unissued_i) begin
            state_d[e] = ST_FREE;
          end else if (issue_fire && (iptr_q == IDW'(e))) begin
            state_d[e] = ST_ISSUED;
          end
        end
        ST_ISSUED: begin
          if (wb_hit[e]) state_d[e] = ST_DONE;
        end
        ST_DONE: begin
          if (retire_mask[e]) state_d[e] = ST_FREE;
        end
      endcase
      if (flush_i) state_d[e] = ST_FREE;
    end

    head_d  = head_q + retire_n[IDW-1:0];
    iptr_d  = iptr_q + IDW'(issue_fire);
    tail_d  = flush_unissued_i ? iptr_q : tail_q + IDW'(alloc_fire);
    count_d = count_q + CNTW'(alloc_fire) - retire_n - (flush_unissued_i ? unissued_n : '0);
    if (flush_i) begin
      head_d  = '0;
      iptr_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      iptr_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
        state_q[e] <= ST_FREE;
      end
    end else begin
      head_q  <= head_d;
      iptr_q  <= iptr_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Payload and result storage carry no reset; they are only observed behind a valid state.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      payload_q[tail_q] <= alloc_payload_i;
    end
    for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
      if (wb_hit[e]) begin
        data_q[e] <= wb_data[e];
        ex_q[e]   <= wb_ex[e];
      end
    end
  end

endmodule

// File: tb/tb_issue_sb_queue.sv
// Bench for issue_sb_queue: directed scenarios plus randomized traffic checked against
// an age-ordered record queue model.
module tb_issue_sb_queue;

  localparam int N   = 4;
  localparam int WB  = 2;
  localparam int CP  = 2;
  localparam int PW  = 16;
  localparam int XL  = 32;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, flush_un;
  logic             alloc_valid, alloc_ready;
  logic [PW-1:0]    alloc_pay;
  logic [IDW-1:0]   alloc_id;
  logic             issue_valid, issue_ready;
  logic [PW-1:0]    issue_pay;
  logic [IDW-1:0]   issue_id;
  logic [WB-1:0]    wb_valid, wb_ex;
  logic [WB*IDW-1:0] wb_id;
  logic [WB*XL-1:0] wb_data;
  logic [CP-1:0]    commit_valid, commit_ex, commit_ack;
  logic [CP*PW-1:0] commit_pay;
  logic [CP*XL-1:0] commit_data;
  logic             full, empty;
  logic [IDW:0]     count;

  issue_sb_queue #(
    .NR_ENTRIES(N), .NR_WB_PORTS(WB), .NR_COMMIT_PORTS(CP), .PAYLOAD_W(PW), .XLEN(XL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_unissued_i(flush_un),
    .alloc_valid_i(alloc_valid), .alloc_payload_i(alloc_pay), .alloc_ready_o(alloc_ready),
    .alloc_id_o(alloc_id), .issue_valid_o(issue_valid), .issue_payload_o(issue_pay),
    .issue_id_o(issue_id), .issue_ready_i(issue_ready), .wb_valid_i(wb_valid),
    .wb_id_i(wb_id), .wb_data_i(wb_data), .wb_ex_i(wb_ex), .commit_valid_o(commit_valid),
    .commit_payload_o(commit_pay), .commit_data_o(commit_data), .commit_ex_o(commit_ex),
    .commit_ack_i(commit_ack), .full_o(full), .empty_o(empty), .count_o(count)
  );

  int checks = 0;
  int failures = 0;

  // Model: in-flight instructions in age order; st 1=waiting issue, 2=executing, 3=result ready.
  typedef struct {
    int            id;
    logic [PW-1:0] pay;
    int            st;
    logic [XL-1:0] data;
    logic          ex;
  } rec_t;
  rec_t mq[$];
  int   m_tail;

  logic          e_ready, e_iv;
  int            e_alloc_id, e_iid;
  logic [PW-1:0] e_ipay;
  logic [CP-1:0] e_cv;
  logic [PW-1:0] e_cpay [CP];
  logic [XL-1:0] e_cdata[CP];
  logic          e_cex  [CP];

  function automatic void model_expect();
    logic run;
    e_ready    = (mq.size() < N) && !flush && !flush_un;
    e_alloc_id = m_tail;
    e_iv = 1'b0; e_iid = 0; e_ipay = '0;
    foreach (mq[i]) if (mq[i].st == 1 && !e_iv) begin
      e_iv = 1'b1; e_iid = mq[i].id; e_ipay = mq[i].pay;
    end
    e_cv = '0; run = 1'b1;
    for (int k = 0; k < CP; k++) begin
      e_cpay[k] = '0; e_cdata[k] = '0; e_cex[k] = 1'b0;
      run = run && (k < mq.size()) && (mq[k].st == 3);
      if (run) begin
        e_cv[k] = 1'b1; e_cpay[k] = mq[k].pay; e_cdata[k] = mq[k].data; e_cex[k] = mq[k].ex;
      end
    end
  endfunction

  function automatic void model_update();
    int   n, id, first;
    logic run;
    bit   claimed[N];
    model_expect();
    if (rst || flush) begin
      mq.delete(); m_tail = 0; return;
    end
    n = 0; run = 1'b1;
    for (int k = 0; k < CP; k++) begin
      if (run && e_cv[k] && commit_ack[k]) n++; else run = 1'b0;
    end
    for (int p = 0; p < WB; p++) begin
      if (wb_valid[p]) begin
        id = int'(wb_id[p*IDW +: IDW]);
        if (!claimed[id]) begin
          claimed[id] = 1'b1;
          foreach (mq[i]) if (mq[i].id == id && mq[i].st == 2) begin
            mq[i].st = 3; mq[i].data = wb_data[p*XL +: XL]; mq[i].ex = wb_ex[p];
          end
        end
      end
    end
    if (flush_un) begin
      first = -1;
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].st == 1) begin
        first = mq[i].id; mq.delete(i);
      end
      if (first >= 0) m_tail = first;
    end else if (issue_ready && e_iv) begin
      foreach (mq[i]) if (mq[i].st == 1) begin mq[i].st = 2; break; end
    end
    if (alloc_valid && e_ready) begin
      mq.push_back('{id: m_tail, pay: alloc_pay, st: 1, data: '0, ex: 1'b0});
      m_tail = (m_tail + 1) % N;
    end
    repeat (n) void'(mq.pop_front());
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; flush_un = 0; alloc_valid = 0; alloc_pay = '0; issue_ready = 0;
    wb_valid = '0; wb_id = '0; wb_data = '0; wb_ex = '0; commit_ack = '0;
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1; tick(); rst = 0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0b exp=0", issue_valid); end
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL reset_commit_valid got=%b exp=00", commit_valid); end
    checks++; if ({full, empty, count} !== {1'b0, 1'b1, 3'd0}) begin failures++; $display("FAIL reset_status got full=%0b empty=%0b count=%0d exp 0/1/0", full, empty, count); end
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    alloc_valid = 1; alloc_pay = 16'hA0A0; #1;
    checks++; if (alloc_id !== 2'd0) begin failures++; $display("FAIL basic_alloc_id got=%0d exp=0", alloc_id); end
    tick(); alloc_valid = 0; #1;
    checks++; if ({issue_valid, issue_id, issue_pay} !== {1'b1, 2'd0, 16'hA0A0}) begin failures++; $display("FAIL basic_issue got v=%0b id=%0d pay=%h exp 1/0/a0a0", issue_valid, issue_id, issue_pay); end
    issue_ready = 1; tick(); issue_ready = 0;
    wb_valid = 2'b01; wb_id = '0; wb_data = {32'h0, 32'h55}; tick(); wb_valid = '0; #1;
    checks++; if ({commit_valid, commit_data[XL-1:0]} !== {2'b01, 32'h55}) begin failures++; $display("FAIL basic_commit got v=%b data=%h exp 01/55", commit_valid, commit_data[XL-1:0]); end
    commit_ack = 2'b01; tick(); commit_ack = '0; #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < N; i++) begin
      alloc_valid = 1; alloc_pay = 16'(i + 16'h100); #1;
      checks++; if (alloc_id !== 2'(i)) begin failures++; $display("FAIL full_alloc_id got=%0d exp=%0d", alloc_id, i); end
      tick();
    end
    alloc_valid = 0; #1;
    checks++; if ({full, alloc_ready, count} !== {1'b1, 1'b0, 3'd4}) begin failures++; $display("FAIL full_status got full=%0b ready=%0b count=%0d exp 1/0/4", full, alloc_ready, count); end
    issue_ready = 1; tick(); issue_ready = 0;
    wb_valid = 2'b01; wb_id = '0; wb_data = 64'h1234; tick(); wb_valid = '0;
    alloc_valid = 1; commit_ack = 2'b01; #1;
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_commit_no_alloc got ready=%0b exp=0", alloc_ready); end
    tick(); commit_ack = '0; #1;
    checks++; if ({count, alloc_ready, alloc_id} !== {3'd3, 1'b1, 2'd0}) begin failures++; $display("FAIL wrap_alloc got count=%0d ready=%0b id=%0d exp 3/1/0", count, alloc_ready, alloc_id); end
    tick(); alloc_valid = 0; #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL wrap_refill got count=%0d exp=4", count); end
  endtask

  task automatic test_ooo_wb();
    do_reset();
    alloc_valid = 1; tick();
    issue_ready = 1; tick();
    alloc_valid = 0; tick(); issue_ready = 0;
    wb_valid = 2'b01; wb_id = 4'd1; wb_data = 64'h11; tick(); #1;
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL ooo_wb_young got=%b exp=00", commit_valid); end
    wb_id = 4'd0; wb_data = 64'h10; tick(); wb_valid = '0; #1;
    checks++; if (commit_valid !== 2'b11) begin failures++; $display("FAIL ooo_wb_old got=%b exp=11", commit_valid); end
    commit_ack = 2'b10; tick(); #1;
    checks++; if ({commit_valid, count} !== {2'b11, 3'd2}) begin failures++; $display("FAIL ooo_nonprefix_ack got v=%b count=%0d exp 11/2", commit_valid, count); end
    commit_ack = 2'b11; tick(); commit_ack = '0; #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL ooo_dual_retire got count=%0d exp=0", count); end
  endtask

  task automatic test_wb_conflict();
    do_reset();
    alloc_valid = 1; tick(); alloc_valid = 0;
    issue_ready = 1; tick(); issue_ready = 0;
    wb_valid = 2'b11; wb_id = 4'b0000; wb_data = {32'h2, 32'h1}; tick(); wb_valid = '0; #1;
    checks++; if ({commit_valid, commit_data[XL-1:0]} !== {2'b01, 32'h1}) begin failures++; $display("FAIL wb_conflict got v=%b data=%h exp 01/1", commit_valid, commit_data[XL-1:0]); end
    commit_ack = 2'b01; tick(); commit_ack = '0;
    alloc_valid = 1; tick(); alloc_valid = 0;
    wb_valid = 2'b01; wb_id = 4'd1; wb_data = 64'h99; tick(); wb_valid = '0; #1;
    checks++; if ({commit_valid, issue_valid, issue_id} !== {2'b00, 1'b1, 2'd1}) begin failures++; $display("FAIL wb_illegal got cv=%b iv=%0b iid=%0d exp 00/1/1", commit_valid, issue_valid, issue_id); end
  endtask

  task automatic setup_three();
    do_reset();
    alloc_valid = 1; tick();
    issue_ready = 1; tick();
    issue_ready = 0; tick();
    alloc_valid = 0; #1;
  endtask

  task automatic test_flushes();
    setup_three();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flushu_pre_count got=%0d exp=3", count); end
    flush_un = 1; alloc_valid = 1; issue_ready = 1; #1;
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL flushu_ready got=%0b exp=0", alloc_ready); end
    tick(); clear_inputs(); #1;
    checks++; if ({count, alloc_id, issue_valid} !== {3'd1, 2'd1, 1'b0}) begin failures++; $display("FAIL flush_unissued got count=%0d id=%0d iv=%0b exp 1/1/0", count, alloc_id, issue_valid); end
    setup_three();
    flush = 1; alloc_valid = 1; issue_ready = 1; tick(); clear_inputs(); #1;
    checks++; if ({count, alloc_id, empty} !== {3'd0, 2'd0, 1'b1}) begin failures++; $display("FAIL flush_all got count=%0d id=%0d empty=%0b exp 0/0/1", count, alloc_id, empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_valid = 1; issue_ready = 1; tick(); tick(); tick();
    alloc_valid = 0; tick(); issue_ready = 0;
    wb_valid = 2'b11; wb_id = {2'd1, 2'd0}; wb_data = {32'hB, 32'hA}; tick();
    wb_valid = 2'b01; wb_id = {2'd0, 2'd2}; tick(); wb_valid = '0; #1;
    checks++; if ({commit_valid, count} !== {2'b11, 3'd3}) begin failures++; $display("FAIL rstmid_pre got v=%b count=%0d exp 11/3", commit_valid, count); end
    rst = 1; flush = 1; tick(); rst = 0; flush = 0; #1;
    checks++; if ({commit_valid, empty, alloc_id, issue_valid} !== {2'b00, 1'b1, 2'd0, 1'b0}) begin failures++; $display("FAIL rstmid_post got cv=%b empty=%0b id=%0d iv=%0b exp 00/1/0/0", commit_valid, empty, alloc_id, issue_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 99) < 2);
      flush_un    = ($urandom_range(0, 99) < 3);
      alloc_valid = ($urandom_range(0, 99) < 60);
      alloc_pay   = 16'($urandom);
      issue_ready = ($urandom_range(0, 99) < 60);
      wb_valid    = 2'($urandom);
      wb_id       = 4'($urandom);
      wb_data     = {$urandom, $urandom};
      wb_ex       = 2'($urandom);
      commit_ack  = 2'($urandom);
      #1;
      model_expect();
      checks++; if ({full, empty, count} !== {mq.size() == N, mq.size() == 0, 3'(mq.size())}) begin failures++; $display("FAIL rnd_status cyc=%0d got full=%0b empty=%0b count=%0d exp count=%0d", c, full, empty, count, mq.size()); end
      checks++; if (alloc_ready !== e_ready) begin failures++; $display("FAIL rnd_alloc_ready cyc=%0d got=%0b exp=%0b", c, alloc_ready, e_ready); end
      checks++; if (alloc_id !== 2'(e_alloc_id)) begin failures++; $display("FAIL rnd_alloc_id cyc=%0d got=%0d exp=%0d", c, alloc_id, e_alloc_id); end
      checks++; if (issue_valid !== e_iv) begin failures++; $display("FAIL rnd_issue_valid cyc=%0d got=%0b exp=%0b", c, issue_valid, e_iv); end
      if (e_iv) begin
        checks++; if ({issue_id, issue_pay} !== {2'(e_iid), e_ipay}) begin failures++; $display("FAIL rnd_issue cyc=%0d got id=%0d pay=%h exp id=%0d pay=%h", c, issue_id, issue_pay, e_iid, e_ipay); end
      end
      checks++; if (commit_valid !== e_cv) begin failures++; $display("FAIL rnd_commit_valid cyc=%0d got=%b exp=%b", c, commit_valid, e_cv); end
      for (int k = 0; k < CP; k++) begin
        if (e_cv[k]) begin
          checks++; if ({commit_pay[k*PW +: PW], commit_data[k*XL +: XL], commit_ex[k]} !== {e_cpay[k], e_cdata[k], e_cex[k]}) begin failures++; $display("FAIL rnd_commit%0d cyc=%0d got pay=%h data=%h ex=%0b exp pay=%h data=%h ex=%0b", k, c, commit_pay[k*PW +: PW], commit_data[k*XL +: XL], commit_ex[k], e_cpay[k], e_cdata[k], e_cex[k]); end
        end
      end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    mq.delete();
    m_tail = 0;
    test_reset();
    test_basic();
    test_full_wrap();
    test_ooo_wb();
    test_wb_conflict();
    test_flushes();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
